// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Decode-stage hazard detector for the in-order pipeline. A shift-register
// scoreboard remembers the last DEPTH issued instructions (destination
// register plus remaining result latency). When the instruction in decode reads
// a register whose producer has not yet reached its forwarding point, the
// block raises stall.
//
// Optional feature macro: HDU_STALL_COUNT_EN
//   When this macro is defined, the stall_count port and a saturating 16-bit
//   stall-cycle counter are present. When it is undefined, neither exists.
//
// Ports:
//   clk                        rising-edge clock
//   rst                        asynchronous active-high reset
//   issue_valid                decode holds a valid instruction
//   issue_opcode               decode opcode
//   issue_rs1 / issue_rs2      source register addresses
//   issue_rs1_used / _rs2_used the source register is actually read
//   issue_rd / issue_rd_we     destination register and its write enable
//   flush                      squash all in-flight tracking (branch taken)
//   stall                      hold decode and inject a bubble
//   hazard_rs1 / hazard_rs2    per-source hazard flags
//   stall_count                cumulative stall cycles (HDU_STALL_COUNT_EN only)
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int                     OPCODE_W    = 4,
  parameter int                     REG_W       = 4,
  parameter logic [OPCODE_W-1:0]    LOAD_OPCODE = 4'b1010,
  parameter int                     LOAD_LAT    = 2,
  parameter logic [OPCODE_W-1:0]    MUL_OPCODE  = 4'b1011,
  parameter int                     MUL_LAT     = 3,
  parameter int                     DEPTH       = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic [OPCODE_W-1:0] issue_opcode,
  input  logic [REG_W-1:0]    issue_rs1,
  input  logic [REG_W-1:0]    issue_rs2,
  input  logic                issue_rs1_used,
  input  logic                issue_rs2_used,
  input  logic [REG_W-1:0]    issue_rd,
  input  logic                issue_rd_we,
  input  logic                flush,
  output logic                stall,
  output logic                hazard_rs1,
  output logic                hazard_rs2
`ifdef HDU_STALL_COUNT_EN
  ,
  output logic [15:0]         stall_count
`endif
);

  localparam int REM_W = $clog2(DEPTH + 1);

  // Scoreboard slots; index 0 holds the most recently issued instruction.
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [REG_W-1:0] rd_q  [DEPTH];
  logic [REG_W-1:0] rd_d  [DEPTH];
  logic [REM_W-1:0] rem_q [DEPTH];
  logic [REM_W-1:0] rem_d [DEPTH];

  logic hit_rs1, hit_rs2;
  logic slot0_valid;

  // Result latency an instruction carries into the scoreboard. Anything that
  // is not a long-latency class is forwardable right away (rem = 0).
  function automatic logic [REM_W-1:0] entry_rem(input logic [OPCODE_W-1:0] op);
    logic [REM_W-1:0] r;
    r = '0;
    if (op == LOAD_OPCODE) r = REM_W'(LOAD_LAT);
    else if (op == MUL_OPCODE) r = REM_W'(MUL_LAT);
    return r;
  endfunction

  function automatic logic [REM_W-1:0] dec_sat(input logic [REM_W-1:0] r);
    return (r == '0) ? '0 : r - 1'b1;
  endfunction

  // Hazard detection: any live slot that is still short of its forwarding
  // point and writes the register being read. Register 0 is hardwired zero.
  always_comb begin
    hit_rs1 = 1'b0;
    hit_rs2 = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_q[k] && (rem_q[k] != '0)) begin
        if (rd_q[k] == issue_rs1) hit_rs1 = 1'b1;
        if (rd_q[k] == issue_rs2) hit_rs2 = 1'b1;
      end
    end
    hazard_rs1 = issue_valid & issue_rs1_used & (issue_rs1 != '0) & hit_rs1;
    hazard_rs2 = issue_valid & issue_rs2_used & (issue_rs2 != '0) & hit_rs2;
    // A flush squashes the decode instruction anyway, so holding it is pointless.
    stall      = (hazard_rs1 | hazard_rs2) & ~flush;
  end

  // Next scoreboard state: shift toward older slots while ageing the latency.
  // A stalled instruction does not issue, so slot 0 receives a bubble.
  always_comb begin
    slot0_valid = issue_valid & issue_rd_we & ~stall & ~flush;
    valid_d[0]  = slot0_valid;
    rd_d[0]     = issue_rd;
    rem_d[0]    = slot0_valid ? entry_rem(issue_opcode) : '0;
    for (int k = 1; k < DEPTH; k++) begin
      valid_d[k] = valid_q[k-1] & ~flush;
      rd_d[k]    = rd_q[k-1];
      rem_d[k]   = flush ? '0 : dec_sat(rem_q[k-1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k]  <= '0;
        rem_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k]  <= rd_d[k];
        rem_q[k] <= rem_d[k];
      end
    end
  end

`ifdef HDU_STALL_COUNT_EN
  logic [15:0] stall_count_q, stall_count_d;

  // Saturating counter so a long stall storm never wraps back to a small value.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 16'hFFFF)) stall_count_d = stall_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_count_q <= '0;
    else     stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
`timescale 1ns/1ps
module tb_hazard_scoreboard;

  localparam int         DEPTH = 3;
  localparam logic [3:0] LD    = 4'b1010;
  localparam logic [3:0] MU    = 4'b1011;
  localparam logic [3:0] AL    = 4'b0001;
  localparam int         RING  = 16;

  logic       clk;
  logic       rst;
  logic       issue_valid;
  logic [3:0] issue_opcode;
  logic [3:0] issue_rs1, issue_rs2;
  logic       issue_rs1_used, issue_rs2_used;
  logic [3:0] issue_rd;
  logic       issue_rd_we;
  logic       flush;
  logic       stall, hazard_rs1, hazard_rs2;
`ifdef HDU_STALL_COUNT_EN
  logic [15:0] stall_count;
  int          exp_cnt = 0;
`endif

  int checks = 0;
  int errors = 0;

  hazard_scoreboard #(
    .OPCODE_W(4), .REG_W(4), .LOAD_OPCODE(LD), .LOAD_LAT(2),
    .MUL_OPCODE(MU), .MUL_LAT(3), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_opcode(issue_opcode),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
    .issue_rd(issue_rd), .issue_rd_we(issue_rd_we),
    .flush(flush),
    .stall(stall), .hazard_rs1(hazard_rs1), .hazard_rs2(hazard_rs2)
`ifdef HDU_STALL_COUNT_EN
    , .stall_count(stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // History of what issued in each cycle; a producer issued j cycles ago with
  // latency L still blocks readers while L >= j and it is within DEPTH cycles.
  logic       hv   [RING];
  logic [3:0] hrd  [RING];
  int         hlat [RING];
  int         cyc        = 0;
  int         last_clear = -1;

  function automatic int lat_of(input logic [3:0] op);
    if (op == LD) return 2;
    if (op == MU) return 3;
    return 0;
  endfunction

  function automatic logic model_hit(input logic [3:0] rs);
    for (int j = 1; j <= DEPTH; j++) begin
      int t;
      t = cyc - j;
      if (t >= 0 && t > last_clear && hv[t % RING] && hlat[t % RING] >= j && hrd[t % RING] == rs)
        return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    logic e1, e2, es;
    if (rst) begin
      e1 = 1'b0; e2 = 1'b0; es = 1'b0;
    end else begin
      e1 = issue_valid && issue_rs1_used && issue_rs1 != 4'd0 && model_hit(issue_rs1);
      e2 = issue_valid && issue_rs2_used && issue_rs2 != 4'd0 && model_hit(issue_rs2);
      es = (e1 || e2) && !flush;
    end
    chk("m_stall", {31'd0, stall}, {31'd0, es});
    chk("m_hazard_rs1", {31'd0, hazard_rs1}, {31'd0, e1});
    chk("m_hazard_rs2", {31'd0, hazard_rs2}, {31'd0, e2});
`ifdef HDU_STALL_COUNT_EN
    if (rst) exp_cnt = 0;
    chk("m_stall_count", {16'd0, stall_count}, exp_cnt);
    if (!rst && es && exp_cnt < 65535) exp_cnt++;
`endif
    hv[cyc % RING]   = !rst && issue_valid && issue_rd_we && !es && !flush;
    hrd[cyc % RING]  = issue_rd;
    hlat[cyc % RING] = lat_of(issue_opcode);
    if (rst || flush) last_clear = cyc;
    cyc++;
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] r1, input logic u1,
                       input logic [3:0] r2, input logic u2, input logic [3:0] rd, input logic we,
                       input logic fl);
    @(posedge clk);
    #1;
    issue_valid = v; issue_opcode = op;
    issue_rs1 = r1; issue_rs1_used = u1;
    issue_rs2 = r2; issue_rs2_used = u2;
    issue_rd = rd; issue_rd_we = we; flush = fl;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, AL, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic run_load_use();
    drive(1, LD, 0, 0, 0, 0, 3, 1, 0);
    chk("ld_issue_stall", {31'd0, stall}, 0);
    for (int i = 0; i < 2; i++) begin
      drive(1, AL, 3, 1, 0, 0, 6, 1, 0);
      chk("ld_use_stall", {31'd0, stall}, 1);
      chk("ld_use_hz1", {31'd0, hazard_rs1}, 1);
    end
    drive(1, AL, 3, 1, 0, 0, 6, 1, 0);
    chk("ld_use_release", {31'd0, stall}, 0);
    idle(3);
  endtask

  initial begin
    rst = 1'b1;
    issue_valid = 0; issue_opcode = AL; issue_rs1 = 0; issue_rs2 = 0;
    issue_rs1_used = 0; issue_rs2_used = 0; issue_rd = 0; issue_rd_we = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall", {31'd0, stall}, 0);
    chk("reset_hz1", {31'd0, hazard_rs1}, 0);
    rst = 1'b0;
    idle(2);

    // Load then dependent reader: two stall cycles.
    run_load_use();

    // Mul, one independent instruction, then reader on rs2.
    drive(1, MU, 0, 0, 0, 0, 5, 1, 0);
    drive(1, AL, 1, 1, 2, 1, 7, 1, 0);
    chk("mul_indep_stall", {31'd0, stall}, 0);
    for (int i = 0; i < 2; i++) begin
      drive(1, AL, 2, 1, 5, 1, 8, 1, 0);
      chk("mul_use_stall", {31'd0, stall}, 1);
      chk("mul_use_hz2", {31'd0, hazard_rs2}, 1);
      chk("mul_use_hz1", {31'd0, hazard_rs1}, 0);
    end
    drive(1, AL, 2, 1, 5, 1, 8, 1, 0);
    chk("mul_use_release", {31'd0, stall}, 0);
    idle(4);

    // r0 never hazards; ALU results forward immediately.
    drive(1, LD, 0, 0, 0, 0, 0, 1, 0);
    drive(1, AL, 0, 1, 0, 1, 9, 1, 0);
    chk("r0_stall", {31'd0, stall}, 0);
    drive(1, AL, 0, 0, 0, 0, 4, 1, 0);
    drive(1, AL, 4, 1, 0, 0, 9, 1, 0);
    chk("alu_fwd_stall", {31'd0, stall}, 0);
    idle(3);

    // Flush with a dependent instruction in decode.
    drive(1, LD, 0, 0, 0, 0, 3, 1, 0);
    drive(1, AL, 3, 1, 0, 0, 6, 1, 1);
    chk("flush_stall", {31'd0, stall}, 0);
    drive(1, AL, 3, 1, 0, 0, 6, 1, 0);
    chk("post_flush_stall", {31'd0, stall}, 0);
    idle(3);

    // Youngest producer (mul) defines release: three stall cycles.
    drive(1, LD, 0, 0, 0, 0, 3, 1, 0);
    drive(1, MU, 0, 0, 0, 0, 3, 1, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, AL, 3, 1, 0, 0, 6, 1, 0);
      chk("youngest_stall", {31'd0, stall}, 1);
    end
    drive(1, AL, 3, 1, 0, 0, 6, 1, 0);
    chk("youngest_release", {31'd0, stall}, 0);
    idle(3);

    // An invalid decode slot never stalls; one gap leaves one stall cycle.
    drive(1, LD, 0, 0, 0, 0, 3, 1, 0);
    drive(0, AL, 3, 1, 0, 0, 6, 1, 0);
    chk("bubble_stall", {31'd0, stall}, 0);
    drive(1, AL, 3, 1, 0, 0, 6, 1, 0);
    chk("gap_stall", {31'd0, stall}, 1);
    drive(1, AL, 3, 1, 0, 0, 6, 1, 0);
    chk("gap_release", {31'd0, stall}, 0);
    idle(3);

    // Asynchronous reset in the middle of a stall.
    drive(1, LD, 0, 0, 0, 0, 3, 1, 0);
    drive(1, AL, 3, 1, 0, 0, 6, 1, 0);
    chk("pre_rst_stall", {31'd0, stall}, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_stall", {31'd0, stall}, 0);
    chk("rst_mid_hz1", {31'd0, hazard_rs1}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1, AL, 3, 1, 0, 0, 6, 1, 0);
    chk("post_rst_dep", {31'd0, stall}, 0);
    drive(1, AL, 1, 1, 2, 1, 7, 1, 0);
    chk("post_rst_indep", {31'd0, stall}, 0);
    idle(3);

`ifdef HDU_STALL_COUNT_EN
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    run_load_use();
    run_load_use();
    chk("count_after_two", {16'd0, stall_count}, 4);
    // Self-dependent mul keeps the pipe stalled three cycles out of four.
    for (int i = 0; i < 90000 && stall_count != 16'hFFFF; i++)
      drive(1, MU, 5, 1, 0, 0, 5, 1, 0);
    repeat (8) drive(1, MU, 5, 1, 0, 0, 5, 1, 0);
    chk("count_saturate", {16'd0, stall_count}, 32'h0000FFFF);
    idle(3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end

endmodule
